// File: rtl/proc_pkg.sv
// proc_pkg: fetch state encoding, datapath widths and instruction field layout shared with decode
package proc_pkg;
  localparam int INST_W = 16;
  localparam int ADDR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int OPC_W = 4;
  localparam int RS_LSB = 9;
  localparam int RT_LSB = 6;
  localparam int RD_LSB = 3;
  localparam int REG_W = 3;
  localparam int FUNC_LSB = 0;
  localparam int FUNC_W = 3;
  localparam int IMM_W = 6;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} fetch_state_t;
  function automatic logic [OPC_W-1:0] opcode(input logic [INST_W-1:0] i);
    return i[OPC_LSB +: OPC_W];
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instruction} pairs between fetch and decode
module fetch_buffer
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_data,
  output logic [1:0]        o_count,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_data
);
  logic [ADDR_W-1:0] r_pc [2];
  logic [INST_W-1:0] r_data [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  // storage and pointers; clear wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '{'0, '0};
      r_data <= '{'0, '0};
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_clr) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_pc[r_wp]   <= i_pc;
        r_data[r_wp] <= i_data;
        r_wp         <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end
  assign o_count = r_cnt;
  assign o_pc    = r_pc[r_rp];
  assign o_data  = r_data[r_rp];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetcher with redirect flush and 2-entry decode buffer
module instruction_fetch
  import proc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [ADDR_W-1:0] inst_pc
);
  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_flush_addr;
  logic [ADDR_W-1:0] w_pc_n;
  logic [ADDR_W-1:0] w_flush_addr_n;
  logic              w_req;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [1:0]        w_count;
  // state, fetch pc and the address of a request being flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_flush_addr <= RESET_PC;
    end else begin
      r_state      <= w_next;
      r_pc         <= w_pc_n;
      r_flush_addr <= w_flush_addr_n;
    end
  end
  // request holds until ack because count only grows on an ack; redirect mid-request parks the old address in FLUSH
  always_comb begin
    w_req          = (r_state == S_REQ && w_count != 2'd2) || r_state == S_FLUSH;
    w_ack          = imem_ack && w_req;
    w_valid        = w_count != 2'd0;
    w_pop          = w_valid && inst_ready;
    w_push         = w_ack && r_state == S_REQ && !redirect_valid;
    w_next         = r_state == S_IDLE  ? S_REQ :
                     r_state == S_FLUSH ? (w_ack ? S_REQ : S_FLUSH) :
                     (redirect_valid && w_req && !w_ack ? S_FLUSH : S_REQ);
    w_flush_addr_n = (r_state == S_REQ && w_next == S_FLUSH) ? r_pc : r_flush_addr;
    w_pc_n         = redirect_valid ? redirect_pc : w_push ? r_pc + ADDR_W'(1) : r_pc;
  end
  fetch_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (redirect_valid),
    .i_pc    (r_pc),
    .i_data  (imem_rdata),
    .o_count (w_count),
    .o_pc    (inst_pc),
    .o_data  (instruction)
  );
  assign imem_req   = w_req;
  assign imem_addr  = r_state == S_FLUSH ? r_flush_addr : r_pc;
  assign inst_valid = w_valid;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of two fetchers (RESET_PC 0000 and FFFF) against a queue model
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req [2];
  logic [15:0] addr [2];
  logic        ack [2];
  logic [15:0] rdata [2];
  logic        rv [2];
  logic [15:0] rpc [2];
  logic        iv [2];
  logic        rdy [2];
  logic [15:0] ins [2];
  logic [15:0] ipc [2];
  logic [15:0] rst_pc [2] = '{16'h0000, 16'hFFFF};
  logic [31:0] q [2][$];
  logic [15:0] acc_pc [2][$];
  logic [15:0] ack_addr [2][$];
  logic [15:0] m_pc [2];
  logic [15:0] m_fa [2];
  bit          m_run [2];
  bit          m_disc [2];
  int          lat [2];
  int          wcnt [2];
  int          checks = 0;
  int          errors = 0;
  int          p_rv = 0, p_rdy = 100, p_noise = 0;
  bit          force_rv = 0, force_ack = 0;
  logic [15:0] force_rpc = '0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack[0]),
    .imem_rdata(rdata[0]), .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .inst_valid(iv[0]),
    .inst_ready(rdy[0]), .instruction(ins[0]), .inst_pc(ipc[0]));
  instruction_fetch #(.RESET_PC(16'hFFFF)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack[1]),
    .imem_rdata(rdata[1]), .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .inst_valid(iv[1]),
    .inst_ready(rdy[1]), .instruction(ins[1]), .inst_pc(ipc[1]));

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5AC3;
  endfunction

  function automatic logic exp_req(input int k);
    return m_run[k] && (m_disc[k] || q[k].size() < 2);
  endfunction

  function automatic logic [15:0] exp_addr(input int k);
    return m_disc[k] ? m_fa[k] : m_pc[k];
  endfunction

  function automatic logic [15:0] qget(input bit which, input int k, input int i);
    if (which) return i < ack_addr[k].size() ? ack_addr[k][i] : 16'hxxxx;
    return i < acc_pc[k].size() ? acc_pc[k][i] : 16'hxxxx;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail_to(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out, required condition never reached", tag);
  endtask

  task automatic upd(input int k, input logic e);
    logic a, p;
    a = ack[k] && e;
    p = q[k].size() != 0 && rdy[k];
    if (!m_run[k]) m_run[k] = 1'b1;
    else if (rv[k]) begin
      if (m_disc[k]) m_disc[k] = !a;
      else if (e && !a) begin
        m_disc[k] = 1'b1;
        m_fa[k] = m_pc[k];
      end
      q[k].delete();
      m_pc[k] = rpc[k];
    end else if (m_disc[k]) m_disc[k] = !a;
    else begin
      if (p) void'(q[k].pop_front());
      if (a) begin
        q[k].push_back({m_pc[k], mem(m_pc[k])});
        m_pc[k]++;
      end
    end
  endtask

  task automatic step();
    logic er [2];
    logic pre_req [2];
    for (int k = 0; k < 2; k++) begin
      er[k] = exp_req(k);
      pre_req[k] = req[k];
      chk($sformatf("imem_req[%0d]", k), 16'(req[k]), 16'(er[k]));
      chk($sformatf("imem_addr[%0d]", k), addr[k], exp_addr(k));
      chk($sformatf("inst_valid[%0d]", k), 16'(iv[k]), 16'(q[k].size() != 0));
      if (q[k].size() != 0) begin
        chk($sformatf("inst_pc[%0d]", k), ipc[k], q[k][0][31:16]);
        chk($sformatf("instruction[%0d]", k), ins[k], q[k][0][15:0]);
      end
      rv[k] = (k == 0 && force_rv) || (m_run[k] && $urandom_range(99) < p_rv);
      rpc[k] = (k == 0 && force_rv) ? force_rpc :
               ($urandom_range(3) == 0 ? 16'hFFFE + 16'($urandom_range(3)) : 16'($urandom));
      rdy[k] = $urandom_range(99) < p_rdy;
      ack[k] = force_ack || (req[k] ? wcnt[k] >= lat[k] : $urandom_range(99) < p_noise);
      rdata[k] = ack[k] ? mem(addr[k]) : 16'($urandom);
      if (iv[k] && rdy[k] && !rv[k]) acc_pc[k].push_back(ipc[k]);
      if (req[k] && ack[k]) ack_addr[k].push_back(addr[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      upd(k, er[k]);
      wcnt[k] = (pre_req[k] && !ack[k]) ? wcnt[k] + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; ack[k] = 0; rdy[k] = 0; rdata[k] = '0; rpc[k] = '0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst imem_req[%0d]", k), 16'(req[k]), 16'd0);
      chk($sformatf("rst imem_addr[%0d]", k), addr[k], rst_pc[k]);
      chk($sformatf("rst inst_valid[%0d]", k), 16'(iv[k]), 16'd0);
      chk($sformatf("rst instruction[%0d]", k), ins[k], 16'h0000);
      chk($sformatf("rst inst_pc[%0d]", k), ipc[k], 16'h0000);
      q[k].delete(); acc_pc[k].delete(); ack_addr[k].delete();
      m_pc[k] = rst_pc[k]; m_fa[k] = rst_pc[k];
      m_run[k] = 0; m_disc[k] = 0; wcnt[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // streaming with 1-cycle memory and an always-ready decoder
    lat = '{1, 1};
    do_reset();
    for (int n = 0; n < 9; n++) step();
    chk("A accepted count", 16'(acc_pc[0].size()), 16'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("A ack addr %0d", i), qget(1, 0, i), 16'(i));
    for (int i = 0; i < 3; i++) chk($sformatf("A inst_pc %0d", i), qget(0, 0, i), 16'(i));
    for (int i = 0; i < 3; i++) chk($sformatf("wrap inst_pc %0d", i), qget(0, 1, i), 16'hFFFF + 16'(i));

    // stalled decoder fills the buffer, then a single pop reopens fetch
    do_reset();
    p_rdy = 0;
    for (int n = 0; n < 8; n++) step();
    chk("B valid", 16'(iv[0]), 16'd1);
    chk("B req low", 16'(req[0]), 16'd0);
    chk("B head pc", ipc[0], 16'h0000);
    chk("B head data", ins[0], mem(16'h0000));
    p_rdy = 100;
    step();
    p_rdy = 0;
    chk("B req after pop", 16'(req[0]), 16'd1);
    chk("B addr after pop", addr[0], 16'h0002);
    chk("B head after pop", ipc[0], 16'h0001);

    // redirect to 0040 while the 0005 request waits on a 3-cycle memory
    do_reset();
    lat = '{3, 3};
    p_rdy = 100;
    for (int n = 0; n < 200 && !(m_pc[0] == 16'h0005 && exp_req(0) && !m_disc[0] && wcnt[0] == 1); n++) step();
    if (!(m_pc[0] == 16'h0005 && wcnt[0] == 1)) fail_to("C reach pc 0005");
    acc_pc[0].delete(); ack_addr[0].delete();
    force_rv = 1; force_rpc = 16'h0040;
    step();
    force_rv = 0;
    chk("C flush req", 16'(req[0]), 16'd1);
    chk("C flush addr", addr[0], 16'h0005);
    for (int n = 0; n < 12; n++) step();
    chk("C flushed ack addr", qget(1, 0, 0), 16'h0005);
    chk("C next req addr", qget(1, 0, 1), 16'h0040);
    chk("C first inst_pc", qget(0, 0, 0), 16'h0040);

    // redirect, ack and pop all in one cycle
    do_reset();
    lat = '{1, 1};
    p_rdy = 0;
    for (int n = 0; n < 50 && !(q[0].size() == 1 && exp_req(0) && !m_disc[0] && wcnt[0] >= lat[0]); n++) step();
    if (!(q[0].size() == 1 && wcnt[0] >= lat[0])) fail_to("D reach ack with one buffered");
    acc_pc[0].delete();
    p_rdy = 100; force_rv = 1; force_rpc = 16'h1234;
    step();
    force_rv = 0;
    chk("D valid cleared", 16'(iv[0]), 16'd0);
    chk("D req", 16'(req[0]), 16'd1);
    chk("D addr", addr[0], 16'h1234);
    for (int n = 0; n < 8; n++) step();
    chk("D first inst_pc", qget(0, 0, 0), 16'h1234);
    chk("D second inst_pc", qget(0, 0, 1), 16'h1235);

    // reset dropped mid-request, then a stray ack right after release
    do_reset();
    lat = '{2, 2};
    for (int n = 0; n < 20 && !(exp_req(0) && wcnt[0] == 1); n++) step();
    if (!(exp_req(0) && wcnt[0] == 1)) fail_to("E reach outstanding request");
    chk("E req before reset", 16'(req[0]), 16'd1);
    do_reset();
    force_ack = 1;
    step();
    force_ack = 0;
    step();
    chk("E no push from late ack", 16'(iv[0]), 16'd0);

    // randomized traffic: redirects, stalls, stray acks, varying memory latency
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      lat = '{1 + int'($urandom_range(3)), 1 + int'($urandom_range(3))};
      p_rv = 3 + 3 * ph;
      p_rdy = 40 + 15 * ph;
      p_noise = 20;
      for (int n = 0; n < 1500; n++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC SHALL be declared: default 16'h0000, the word address fetched first after reset.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock, rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port imem_req SHALL be: output, 1 bit, instruction memory read request.
REQ-005 Port imem_addr SHALL be: output, 16 bits, word address of the request.
REQ-006 Port imem_ack SHALL be: input, 1 bit, single-cycle acknowledge, with imem_rdata valid in the same cycle.
REQ-007 Port imem_rdata SHALL be: input, 16 bits, instruction word returned by memory.
REQ-008 Port redirect_valid SHALL be: input, 1 bit, branch/jump redirect pulse from execute.
REQ-009 Port redirect_pc SHALL be: input, 16 bits, redirect target word address.
REQ-010 Port inst_valid SHALL be: output, 1 bit, instruction available to the decode stage.
REQ-011 Port inst_ready SHALL be: input, 1 bit, the decode stage accepts the instruction.
REQ-012 Port instruction SHALL be: output, 16 bits, instruction word fed to the decoder ([15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] func / [5:0] imm).
REQ-013 Port inst_pc SHALL be: output, 16 bits, word address of the instruction on the instruction port.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and FLUSH; IDLE SHALL go to REQ unconditionally one cycle after reset release.
REQ-015 In REQ, imem_req SHALL assert when buffer count<2, and once asserted it SHALL stay high, with imem_addr=pc held stable, until imem_ack.
REQ-016 On imem_ack in REQ, {pc, imem_rdata} SHALL be pushed into the 2-entry FIFO and pc SHALL become pc+1, wrapping 16'hFFFF->16'h0000.
REQ-017 A new request SHALL be allowed in the cycle after an ack; the fetch path SHALL never have more than one request outstanding.
REQ-018 inst_valid SHALL equal (count!=0), and instruction/inst_pc SHALL come from the FIFO head; data acked in cycle N SHALL be visible at N+1 (1-cycle latency).
REQ-019 The FIFO SHALL pop on inst_valid&&inst_ready, and push and pop in the same cycle SHALL leave count unchanged.
REQ-020 Output data SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-021 On redirect_valid, the FIFO SHALL be cleared (count=0, any pop/push that cycle ignored) and pc SHALL be set to redirect_pc.
REQ-022 A redirect with a request outstanding and no ack in the same cycle SHALL send the FSM to FLUSH, and an ack in the redirect cycle SHALL be discarded, with the FSM staying in REQ.
REQ-023 In FLUSH, imem_req SHALL stay high with the old address until ack, the response SHALL be discarded, pc SHALL not increment, and the FSM SHALL then go to REQ.
REQ-024 A redirect while in FLUSH SHALL update pc to the new target and the FSM SHALL remain in FLUSH.
REQ-025 A redirect with no request outstanding SHALL take effect immediately, with the FSM in REQ issuing the new pc the next cycle.
REQ-026 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force: state=IDLE, pc=RESET_PC, count=0, imem_req=0, inst_valid=0, imem_addr=RESET_PC, instruction=16'h0000, inst_pc=16'h0000.
REQ-028 A reset mid-request SHALL abandon the request, and a late ack arriving after reset SHALL be ignored per REQ-026.

Structure
REQ-029 A shared package proc_pkg SHALL hold the fetch state enum, INST_W=16, ADDR_W=16 and the instruction field positions shared with the decoder.
REQ-030 A sub-module fetch_buffer SHALL implement the 2-entry FIFO (push, pop, clear, count, head data), and the FSM and pc SHALL reside in instruction_fetch.

Verification
REQ-031 Reset with a memory acking every request after 1 cycle and inst_ready=1 SHALL give addresses 0,1,2,3, inst_pc following in order, and one instruction every 2 cycles.
REQ-032 With inst_ready=0 SHALL: 2 instructions buffered, imem_req low, instruction held stable; raising inst_ready for 1 cycle SHALL pop one entry and issue a request for pc=2.
REQ-033 A redirect to 16'h0040 while a request for 16'h0005 is outstanding (3-cycle ack latency) SHALL discard the 0x0005 data, next request address 16'h0040, and first inst_pc 16'h0040.
REQ-034 With RESET_PC=16'hFFFF SHALL: fetched inst_pc sequence FFFF, 0000, 0001.
REQ-035 Simultaneous redirect, ack and pop SHALL give count=0 next cycle, pc=redirect_pc, and the acked word never presented.
REQ-036 rst_n dropped while imem_req=1 SHALL drive outputs to their REQ-027 values asynchronously, and an ack one cycle after release SHALL cause no push.
